// File: rtl/seg7_mux_decoder.sv
// Receive side of a two-digit multiplexed 7-segment bus: settles each digit phase, decodes to BCD,
// and reassembles a 0..59 seconds value. Optional CA-activity watchdog enabled by `define WDOG_EN.
module seg7_mux_decoder #(
    parameter int STABLE_CYCLES = 16,
`ifdef WDOG_EN
    parameter int WDOG_CYCLES   = 3_750_000,
`endif
    parameter int ERR_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       an_i,
    input  logic             ca_i,
    output logic [5:0]       sec_o,
    output logic             sec_vld_o,
    output logic             sec_chg_o,
    output logic             dig_err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             link_ok_o
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [6:0]         an_s1_q, an_s2_q;
    logic               ca_s1_q, ca_s2_q;
    logic [7:0]         samp_q;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [3:0]         tens_q, tens_d, ones_q, ones_d;
    logic               got_t_q, got_t_d, got_o_q, got_o_d;
    logic               frame_q, frame_d;
    logic [5:0]         sec_q, sec_d;
    logic               vld_q, vld_d, chg_q, chg_d, err_q, err_d;
    logic [ERR_W-1:0]   cnt_q, cnt_d;
    logic               link_q;
    logic               ca_edge, wd_to;
    logic [7:0]         cur;

    assign cur     = {ca_s2_q, an_s2_q};
    assign ca_edge = ca_s2_q != samp_q[7];

    // Returns {legal, digit}.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   decode = {1'b1, 4'd0};
            7'h30:   decode = {1'b1, 4'd1};
            7'h6D:   decode = {1'b1, 4'd2};
            7'h79:   decode = {1'b1, 4'd3};
            7'h33:   decode = {1'b1, 4'd4};
            7'h5B:   decode = {1'b1, 4'd5};
            7'h5F:   decode = {1'b1, 4'd6};
            7'h70:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h7B:   decode = {1'b1, 4'd9};
            default: decode = {1'b0, 4'd0};
        endcase
    endfunction

    logic [4:0] dec;
    assign dec = decode(samp_q[6:0]);

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        got_t_d = got_t_q;
        got_o_d = got_o_q;
        frame_d = 1'b0;
        sec_d   = sec_q;
        vld_d   = 1'b0;
        chg_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ca_edge) begin
                    state_d = S_SETTLE;
                    stab_d  = '0;
                end
            end
            S_SETTLE: begin
                if (ca_edge || cur != samp_q) begin
                    stab_d = '0;
                end else if (stab_q == STAB_W'(STABLE_CYCLES - 1)) begin
                    state_d = S_CAPTURE;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // samp_q still holds the sample that was stable for the whole settle window.
                if (!dec[4] || (samp_q[7] && dec[3:0] > 4'd5)) begin
                    err_d   = 1'b1;
                    got_t_d = 1'b0;
                    got_o_d = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else begin
                    if (samp_q[7]) begin
                        tens_d  = dec[3:0];
                        got_t_d = 1'b1;
                    end else begin
                        ones_d  = dec[3:0];
                        got_o_d = 1'b1;
                    end
                    frame_d = got_t_d && got_o_d;
                end
                state_d = ca_edge ? S_SETTLE : S_WAIT;
                stab_d  = '0;
            end
            default: begin
                if (ca_edge) begin
                    state_d = S_SETTLE;
                    stab_d  = '0;
                end
            end
        endcase

        if (frame_q) begin
            sec_d   = 6'(tens_q) * 6'd10 + 6'(ones_q);
            vld_d   = 1'b1;
            chg_d   = sec_d != sec_q;
            got_t_d = 1'b0;
            got_o_d = 1'b0;
        end

        if (wd_to) begin
            state_d = S_IDLE;
            stab_d  = '0;
            got_t_d = 1'b0;
            got_o_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_s1_q <= '0;
            an_s2_q <= '0;
            ca_s1_q <= 1'b0;
            ca_s2_q <= 1'b0;
            samp_q  <= '0;
            state_q <= S_IDLE;
            stab_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            got_t_q <= 1'b0;
            got_o_q <= 1'b0;
            frame_q <= 1'b0;
            sec_q   <= '0;
            vld_q   <= 1'b0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            an_s1_q <= an_i;
            an_s2_q <= an_s1_q;
            ca_s1_q <= ca_i;
            ca_s2_q <= ca_s1_q;
            samp_q  <= cur;
            state_q <= state_d;
            stab_q  <= stab_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            got_t_q <= got_t_d;
            got_o_q <= got_o_d;
            frame_q <= frame_d;
            sec_q   <= sec_d;
            vld_q   <= vld_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // One-shot timeout: the counter parks at WDOG_CYCLES until the next CA edge.
    assign wd_to = !ca_edge && (wd_q == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q   <= '0;
            link_q <= 1'b0;
        end else if (ca_edge) begin
            wd_q   <= '0;
            link_q <= 1'b1;
        end else begin
            if (wd_q != WD_W'(WDOG_CYCLES)) wd_q <= wd_q + 1'b1;
            if (wd_to) link_q <= 1'b0;
        end
    end
`else
    assign wd_to = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) link_q <= 1'b0;
        else         link_q <= 1'b1;
    end
`endif

    assign sec_o     = sec_q;
    assign sec_vld_o = vld_q;
    assign sec_chg_o = chg_q;
    assign dig_err_o = err_q;
    assign err_cnt_o = cnt_q;
    assign link_ok_o = link_q;

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed bench for seg7_mux_decoder: a phase-level model predicts frames and errors,
// and a negedge compare process checks every output against it each cycle.
module tb_seg7_mux_decoder;

    localparam int ERR_MAX = 255;
    localparam int LONG    = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] an;
    logic       ca;
    logic [5:0] sec;
    logic       sec_vld, sec_chg, dig_err, link_ok;
    logic [7:0] err_cnt;

    seg7_mux_decoder #(
`ifdef WDOG_EN
        .WDOG_CYCLES(1000),
`endif
        .STABLE_CYCLES(16),
        .ERR_W(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .an_i(an), .ca_i(ca),
        .sec_o(sec), .sec_vld_o(sec_vld), .sec_chg_o(sec_chg),
        .dig_err_o(dig_err), .err_cnt_o(err_cnt), .link_ok_o(link_ok)
    );

    always #5 clk = ~clk;

    typedef struct { int sec; bit chg; } frame_t;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    frame_t fq[$];
    int     eq[$];
    int     m_sec, m_cnt, m_tens, m_ones, shown_sec, shown_cnt;
    bit     m_gt, m_go, m_prev_ca, chk_en;
    frame_t f;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sec = 0; m_cnt = 0; m_tens = 0; m_ones = 0;
        shown_sec = 0; shown_cnt = 0;
        m_gt = 0; m_go = 0; m_prev_ca = 0;
        fq.delete(); eq.delete();
    endtask

    // A settled phase: look the pattern up, then either store a digit or count an error.
    task automatic model_capture(input bit c, input logic [6:0] p);
        int d = -1;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) d = i;
        if (d < 0 || (c && d > 5)) begin
            if (m_cnt < ERR_MAX) m_cnt++;
            eq.push_back(m_cnt);
            m_gt = 0; m_go = 0;
        end else begin
            if (c) begin m_tens = d; m_gt = 1; end
            else   begin m_ones = d; m_go = 1; end
            if (m_gt && m_go) begin
                int v = m_tens * 10 + m_ones;
                fq.push_back('{v, v != m_sec});
                m_sec = v;
                m_gt = 0; m_go = 0;
            end
        end
    endtask

    task automatic end_phase();
        chk("events_done", fq.size() + eq.size(), 0);
        fq.delete(); eq.delete();
    endtask

    task automatic phase(input bit c, input logic [6:0] p, input int n);
        if (c != m_prev_ca && n >= LONG) model_capture(c, p);
        m_prev_ca = c;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            ca = c; an = p;
        end
        end_phase();
    endtask

    task automatic toggle_phase(input bit c, input logic [6:0] p1, input logic [6:0] p2, input int n);
        m_prev_ca = c;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            ca = c; an = ((k / 8) % 2 != 0) ? p2 : p1;
        end
        end_phase();
    endtask

    task automatic check_reset_outputs();
        chk("rst_sec", sec, 0);
        chk("rst_vld", sec_vld, 0);
        chk("rst_chg", sec_chg, 0);
        chk("rst_err", dig_err, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_link", link_ok, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (sec_vld) begin
                if (fq.size() == 0) chk("unexpected_vld", 1, 0);
                else begin
                    f = fq.pop_front();
                    chk("sec", sec, f.sec);
                    chk("sec_chg", sec_chg, int'(f.chg));
                    shown_sec = f.sec;
                end
            end else begin
                chk("sec_hold", sec, shown_sec);
                chk("chg_idle", sec_chg, 0);
            end
            if (dig_err) begin
                if (eq.size() == 0) chk("unexpected_err", 1, 0);
                else begin
                    shown_cnt = eq.pop_front();
                    chk("err_cnt", err_cnt, shown_cnt);
                end
            end else begin
                chk("cnt_hold", err_cnt, shown_cnt);
            end
`ifndef WDOG_EN
            chk("link_ok", link_ok, 1);
`endif
        end
    end

    initial begin
        rst_n = 1'b0; ca = 1'b0; an = 7'h00; chk_en = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        release_reset();

        // 2-5 frame, then the same frame again, then 5-9
        phase(1'b1, 7'h6D, 600);
        phase(1'b0, 7'h5B, 600);
        chk("t1_sec_lit", sec, 25);
        phase(1'b1, 7'h6D, 600);
        phase(1'b0, 7'h5B, 600);
        phase(1'b1, 7'h5B, 600);
        phase(1'b0, 7'h7B, 600);
        chk("t2_sec_lit", sec, 59);

        // tens 1, an unsettled ones phase, tens 4 overwrites, then ones 1
        phase(1'b1, 7'h30, 600);
        phase(1'b0, 7'h7E, 6);
        phase(1'b1, 7'h33, 600);
        phase(1'b0, 7'h30, 600);
        chk("ovw_sec_lit", sec, 41);

        // tens phase that never settles, then a ones digit alone
        toggle_phase(1'b1, 7'h6D, 7'h79, 400);
        phase(1'b0, 7'h7E, 600);

        // tens digit 6, then a stray ones, then saturation with blank patterns
        phase(1'b1, 7'h5F, 600);
        chk("t4_cnt_lit", err_cnt, 1);
        phase(1'b0, 7'h7E, 600);
        for (int i = 0; i < 300; i++) phase((i % 2) == 0, 7'h00, LONG);
        chk("t4_sat_lit", err_cnt, 255);
        chk("t4_sec_kept", sec, 41);

        // reset in the middle of the ones phase of a 3-7 frame
        phase(1'b1, 7'h79, 600);
        phase(1'b0, 7'h70, 10);
        @(posedge clk);
        #3 chk_en = 1'b0; rst_n = 1'b0;
        #1 check_reset_outputs();
        model_clear();
        repeat (4) @(posedge clk);
        release_reset();
        phase(1'b0, 7'h6D, 200);
        chk("t5_no_frame", sec, 0);
        phase(1'b1, 7'h33, 600);
        phase(1'b0, 7'h6D, 600);
        chk("t5_sec_lit", sec, 42);

`ifdef WDOG_EN
        // CA stuck: the tens digit captured before the timeout is forgotten
        phase(1'b1, 7'h33, 1200);
        m_gt = 0; m_go = 0;
        chk("t6_link_down", link_ok, 0);
        phase(1'b0, 7'h30, 600);
        chk("t6_link_up", link_ok, 1);
        phase(1'b1, 7'h5B, 600);
        chk("t6_sec_lit", sec, 51);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
